// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM encoding and default sizes for the APB arbitrating master
package apb_pkg;
  localparam int APB_AW = 9;
  localparam int APB_DW = 8;
  localparam int APB_TMO = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;
endpackage

// File: rtl/apb_rr_arb2.sv
// apb_rr_arb2: two-way round-robin arbiter, last-grant bit moves only on a grant
module apb_rr_arb2 (
  input  logic       pclk,
  input  logic       presetn,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last;
  always_comb gnt = !en ? 2'b00 : &req ? (last ? 2'b01 : 2'b10) : req;
  always_ff @(posedge pclk) begin
    if (!presetn) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end
endmodule

// File: rtl/apb_arb_master.sv
// apb_arb_master: arbitrates two requesters onto one APB master port with a wait-cycle timeout
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int AW  = APB_AW,
  parameter int DW  = APB_DW,
  parameter int TMO = APB_TMO
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          psel1,
  output logic          psel2,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);
  localparam int CW = $clog2(TMO + 1);
  apb_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] gnt;
  logic id, wr, err, tmo, busy;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  // reset gates the grant so no ready can leak out while presetn is low
  apb_rr_arb2 u_arb (
    .pclk    (pclk),
    .presetn (presetn),
    .req     ({req1_valid, req0_valid}),
    .en      (presetn && state == IDLE),
    .gnt     (gnt)
  );
  assign tmo = cnt == CW'(TMO - 1);
  always_comb begin
    nxt = state == IDLE ? (|gnt ? SETUP : IDLE) :
          state == SETUP ? ACCESS :
          state == ACCESS ? (pready || tmo ? RESP : ACCESS) : IDLE;
    busy = state == SETUP || state == ACCESS;
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    psel1 = busy && !addr[AW-1];
    psel2 = busy && addr[AW-1];
    penable = state == ACCESS;
    pwrite = wr;
    paddr = addr;
    pwdata = wdata;
    rsp_valid = state == RESP;
    rsp_id = rsp_valid && id;
    rsp_rdata = rsp_valid ? rdata : '0;
    rsp_err = rsp_valid && err;
  end
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state <= IDLE;
      cnt <= '0;
      id <= 1'b0;
      wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && |gnt) begin
        id <= gnt[1];
        wr <= gnt[1] ? req1_write : req0_write;
        addr <= gnt[1] ? req1_addr : req0_addr;
        wdata <= gnt[1] ? req1_wdata : req0_wdata;
        cnt <= '0;
      end
      // pready wins over the timeout on the last allowed ACCESS cycle
      if (state == ACCESS) begin
        if (pready) begin
          rdata <= wr ? '0 : prdata;
          err <= pslverr;
        end else if (tmo) begin
          rdata <= '0;
          err <= 1'b1;
        end else cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_apb_arb_master.sv
// tb_apb_arb_master: table-driven transfers plus hand-written contention and reset-abort sequences
module tb_apb_arb_master;
  logic pclk = 1'b0;
  logic presetn;
  logic req0_valid, req0_ready, req0_write;
  logic [8:0] req0_addr;
  logic [7:0] req0_wdata;
  logic req1_valid, req1_ready, req1_write;
  logic [8:0] req1_addr;
  logic [7:0] req1_wdata;
  logic rsp_valid, rsp_id, rsp_err;
  logic [7:0] rsp_rdata;
  logic psel1, psel2, penable, pwrite;
  logic [8:0] paddr;
  logic [7:0] pwdata, prdata;
  logic pready, pslverr;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v0, v1, keep, wr;
    logic [8:0] addr;
    logic [7:0] wdata, prdata;
    logic       slverr;
    int         w;
    logic       exp_id;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_lat;
  } vec_t;
  vec_t vecs[12];
  vec_t vr;

  apb_arb_master dut (
    .pclk(pclk), .presetn(presetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel1(psel1), .psel2(psel2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic v0, input logic v1, input logic wr, input logic [8:0] a,
                           input logic [7:0] d);
    req0_valid = v0;
    req1_valid = v1;
    req0_write = wr;
    req1_write = wr;
    req0_addr = a;
    req1_addr = a;
    req0_wdata = d;
    req1_wdata = d;
  endtask

  // called at a negedge with the DUT in IDLE; returns at the negedge after RESP
  task automatic run(input vec_t v);
    int lat, k;
    logic sel2;
    sel2 = v.addr[8];
    drive_req(v.v0, v.v1, v.wr, v.addr, v.wdata);
    #1;
    chk("two_readys", 32'(req0_ready & req1_ready), 0);
    chk("grant", 32'({req1_ready, req0_ready}), v.exp_id ? 32'd2 : 32'd1);
    @(negedge pclk);
    lat = 1;
    if (!v.keep) drive_req(1'b0, 1'b0, ~v.wr, ~v.addr, ~v.wdata);
    #1;
    chk("setup_psel", 32'({psel2, psel1}), sel2 ? 32'd2 : 32'd1);
    chk("setup_penable", 32'(penable), 0);
    chk("setup_paddr", 32'(paddr), 32'(v.addr));
    chk("setup_pwrite", 32'(pwrite), 32'(v.wr));
    chk("setup_pwdata", 32'(pwdata), 32'(v.wdata));
    chk("setup_ready", 32'(req0_ready | req1_ready), 0);
    k = 0;
    while (lat < 40) begin
      @(negedge pclk);
      lat++;
      if (rsp_valid) break;
      chk("access_state", 32'({psel2, psel1, penable}), sel2 ? 32'd5 : 32'd3);
      chk("access_hold", 32'({pwrite, paddr, pwdata}), 32'({v.wr, v.addr, v.wdata}));
      chk("access_ready", 32'(req0_ready | req1_ready), 0);
      pready = k == v.w;
      pslverr = (k == v.w) && v.slverr;
      prdata = v.prdata;
      k++;
    end
    pready = 1'b0;
    pslverr = 1'b0;
    prdata = 8'h00;
    chk("rsp_latency", 32'(lat), 32'(v.exp_lat));
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_id", 32'(rsp_id), 32'(v.exp_id));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("resp_bus_idle", 32'({psel1, psel2, penable}), 0);
    chk("resp_ready", 32'(req0_ready | req1_ready), 0);
    if (!v.keep) drive_req(1'b0, 1'b0, 1'b0, 9'h000, 8'h00);
    @(negedge pclk);
    chk("rsp_single_pulse", 32'(rsp_valid), 0);
  endtask

  initial begin
    //          v0 v1 kp wr addr     wdata  prdata slv w    id rdata  err lat
    vecs[0]  = '{1, 0, 0, 1, 9'h005, 8'hA5, 8'h00, 0, 0,   0, 8'h00, 0, 3};
    vecs[1]  = '{0, 1, 0, 0, 9'h10C, 8'h00, 8'h3C, 0, 2,   1, 8'h3C, 0, 5};
    vecs[2]  = '{1, 1, 1, 1, 9'h020, 8'h11, 8'h77, 0, 0,   0, 8'h00, 0, 3};
    vecs[3]  = '{1, 1, 1, 0, 9'h120, 8'h00, 8'h42, 0, 1,   1, 8'h42, 0, 4};
    vecs[4]  = '{1, 1, 1, 0, 9'h0AA, 8'h00, 8'hC3, 0, 0,   0, 8'hC3, 0, 3};
    vecs[5]  = '{1, 1, 1, 1, 9'h1FF, 8'h5E, 8'h77, 0, 3,   1, 8'h00, 0, 6};
    vecs[6]  = '{0, 1, 0, 0, 9'h101, 8'h00, 8'h81, 0, 0,   1, 8'h81, 0, 3};
    vecs[7]  = '{1, 0, 0, 1, 9'h044, 8'hE7, 8'h77, 1, 0,   0, 8'h00, 1, 3};
    vecs[8]  = '{1, 0, 0, 0, 9'h0FF, 8'h00, 8'h5A, 0, 2,   0, 8'h5A, 0, 5};
    vecs[9]  = '{1, 0, 0, 0, 9'h0F0, 8'h00, 8'hA1, 0, 15,  0, 8'hA1, 0, 18};
    vecs[10] = '{0, 1, 0, 0, 9'h1C0, 8'h00, 8'h99, 0, 255, 1, 8'h00, 1, 18};
    vecs[11] = '{1, 1, 0, 1, 9'h00F, 8'h3D, 8'h77, 0, 0,   0, 8'h00, 0, 3};
    vr       = '{1, 1, 0, 0, 9'h033, 8'h00, 8'h6C, 0, 0,   0, 8'h6C, 0, 3};
    presetn = 1'b0;
    drive_req(1'b1, 1'b1, 1'b1, 9'h1AB, 8'hCD);
    pready = 1'b1;
    pslverr = 1'b1;
    prdata = 8'hFF;
    repeat (3) @(negedge pclk);
    chk("reset_ready", 32'({req1_ready, req0_ready}), 0);
    chk("reset_bus", 32'({psel1, psel2, penable, pwrite, paddr, pwdata}), 0);
    chk("reset_rsp", 32'({rsp_valid, rsp_id, rsp_err, rsp_rdata}), 0);
    presetn = 1'b1;
    pready = 1'b0;
    pslverr = 1'b0;
    prdata = 8'h00;
    for (int i = 0; i < 12; i++) run(vecs[i]);
    // reset while a transfer waits in ACCESS, then contention must go to req0
    drive_req(1'b1, 1'b1, 1'b0, 9'h150, 8'h00);
    #1;
    chk("pre_reset_grant", 32'({req1_ready, req0_ready}), 2);
    @(negedge pclk);
    @(negedge pclk);
    chk("pre_reset_access", 32'({psel2, penable}), 3);
    @(negedge pclk);
    presetn = 1'b0;
    @(negedge pclk);
    chk("abort_bus", 32'({psel1, psel2, penable}), 0);
    chk("abort_rsp", 32'(rsp_valid), 0);
    chk("abort_ready", 32'({req1_ready, req0_ready}), 0);
    presetn = 1'b1;
    run(vr);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
